inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences the decoder. Owns the PC and fetches one instruction at a time from the memory/icache port.
- Presents the instruction to the decoder with start_decode and holds it until the decoder issues it.
- Advances to the decoder's predicted next_pc on issue. Redirects to correct_pc on misprediction, draining any in-flight fetch first.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  ready; all state frozen when low
- wrong_predicted  input  1  flush request from rob
- correct_pc  input  32  redirect target from rob
- issue_signal  input  1  decoder accepted current instruction
- jalr_stall  input  1  decoder waiting on jalr rs1 dependency
- next_pc  input  32  decoder's predicted next PC
- start_decode  output  1  inst/inst_addr valid to decoder
- inst  output  32  instruction to decoder
- inst_addr  output  32  address of inst
- fetch_req  output  1  fetch request to memory
- fetch_addr  output  32  fetch address, word aligned
- fetch_valid  input  1  one-cycle pulse: fetch_inst valid, request complete
- fetch_inst  input  32  fetched instruction

Behaviour:
- All outputs are registered. Every register updates only on a rising clk_in edge with rdy_in=1, except rst_in. When rdy_in=0, state and outputs hold.
- Reset (rst_in=1 at an edge, regardless of rdy_in):
  - state=IDLE, pc=RESET_PC.
  - start_decode=0, inst=0, inst_addr=0, fetch_req=0, fetch_addr=0.
  - Any outstanding fetch is abandoned; the memory side is reset by the same rst_in.
- State IDLE:
  - Next edge: fetch_req=1, fetch_addr=pc, go to REQ.
- State REQ:
  - fetch_req and fetch_addr are held stable until fetch_valid.
  - On fetch_valid with no flush: inst=fetch_inst, inst_addr=fetch_addr, start_decode=1, fetch_req=0, go to HOLD.
- State HOLD:
  - start_decode=1; inst and inst_addr are stable.
  - If issue_signal=1: start_decode=0, pc=next_pc, fetch_req=1, fetch_addr=next_pc, go to REQ. Issue-to-next-request latency is 1 cycle.
  - If jalr_stall=1 or issue_signal=0: remain in HOLD. The decoder re-evaluates each cycle and no refetch occurs.
- State DRAIN (flush arrived with a fetch in flight):
  - fetch_req=0 and start_decode=0.
  - Wait for fetch_valid and discard fetch_inst.
  - Next edge after that: fetch_req=1, fetch_addr=pc (already set to correct_pc), go to REQ.
- Flush, wrong_predicted=1, has priority over everything:
  - HOLD or IDLE: start_decode=0, pc=correct_pc, fetch_req=1, fetch_addr=correct_pc, go to REQ.
  - REQ, fetch_valid=0 same cycle: pc=correct_pc, fetch_req=0, go to DRAIN.
  - REQ, fetch_valid=1 same cycle: response discarded, pc=correct_pc, fetch_req=1, fetch_addr=correct_pc, stay in REQ.
  - DRAIN: pc updated to the latest correct_pc; stay in DRAIN, or if fetch_valid=1 the same cycle, proceed as the DRAIN exit with the new pc.
- If issue_signal and wrong_predicted are both high, the flush wins and issue_signal is ignored.
- A single request is outstanding at most; fetch_req never rises while a request is pending.
- fetch_valid in HOLD or IDLE is illegal and ignored.
- PC arithmetic is 32-bit unsigned with wrap-around at 2^32.

Optional Feature:
- Macro IF_STALL_CNT_EN.
- When defined, adds output port stall_cycles (32 bits, reset 0). It increments each active cycle with start_decode=1 and issue_signal=0, saturates at 32'hFFFFFFFF, and is not cleared by flush.
- When undefined, the port and counter are absent.

Test Plan:
- Reset with RESET_PC=0, memory returns inst 32'h00500093 after 3 cycles -> fetch_addr=0 in REQ; start_decode=1, inst=32'h00500093, inst_addr=0 in HOLD.
- In HOLD, issue_signal=1 with next_pc=32'h4 -> next cycle start_decode=0, fetch_req=1, fetch_addr=32'h4.
- In HOLD, jalr_stall=1 for 5 cycles then issue_signal=1 with next_pc=32'h100 -> inst held stable 5 cycles, no fetch_req; then fetch_addr=32'h100.
- In REQ at addr 32'h8, wrong_predicted=1 with correct_pc=32'h40, fetch_valid 2 cycles later -> DRAIN, response discarded, start_decode stays 0, then fetch_addr=32'h40.
- wrong_predicted and fetch_valid in the same cycle, correct_pc=32'h80 -> no start_decode; the next request has fetch_addr=32'h80.
- rdy_in=0 for 4 cycles in HOLD, then rst_in=1 mid-REQ -> outputs frozen during the pause; after reset all outputs are 0 and the first fetch_addr is RESET_PC. With IF_STALL_CNT_EN, stall_cycles=0 after reset.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one fetch at a time and holds
// the result for the decoder. Optional macro IF_STALL_CNT_EN adds a stall counter.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc,
  input  logic        issue_signal,
  input  logic        jalr_stall,
  input  logic [31:0] next_pc,
  output logic        start_decode,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
`ifdef IF_STALL_CNT_EN
  input  logic [31:0] fetch_inst,
  output logic [31:0] stall_cycles
`else
  input  logic [31:0] fetch_inst
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        start_decode_d, fetch_req_d;
  logic [31:0] inst_d, inst_addr_d, fetch_addr_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    start_decode_d = start_decode;
    inst_d         = inst;
    inst_addr_d    = inst_addr;
    fetch_req_d    = fetch_req;
    fetch_addr_d   = fetch_addr;
    unique case (state_q)
      IDLE: begin
        state_d      = REQ;
        fetch_req_d  = 1'b1;
        fetch_addr_d = wrong_predicted ? correct_pc : pc_q;
        if (wrong_predicted) pc_d = correct_pc;
      end
      REQ: begin
        if (wrong_predicted) begin
          pc_d = correct_pc;
          if (fetch_valid) begin
            // Response belongs to the wrong path: drop it and re-request at once.
            fetch_req_d  = 1'b1;
            fetch_addr_d = correct_pc;
          end else begin
            fetch_req_d = 1'b0;
            state_d     = DRAIN;
          end
        end else if (fetch_valid) begin
          inst_d         = fetch_inst;
          inst_addr_d    = fetch_addr;
          start_decode_d = 1'b1;
          fetch_req_d    = 1'b0;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (wrong_predicted) begin
          start_decode_d = 1'b0;
          pc_d           = correct_pc;
          fetch_req_d    = 1'b1;
          fetch_addr_d   = correct_pc;
          state_d        = REQ;
        end else if (issue_signal && !jalr_stall) begin
          start_decode_d = 1'b0;
          pc_d           = next_pc;
          fetch_req_d    = 1'b1;
          fetch_addr_d   = next_pc;
          state_d        = REQ;
        end
      end
      DRAIN: begin
        if (wrong_predicted) pc_d = correct_pc;
        if (fetch_valid) begin
          fetch_req_d  = 1'b1;
          fetch_addr_d = wrong_predicted ? correct_pc : pc_q;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      start_decode <= 1'b0;
      inst         <= 32'h0;
      inst_addr    <= 32'h0;
      fetch_req    <= 1'b0;
      fetch_addr   <= 32'h0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      start_decode <= start_decode_d;
      inst         <= inst_d;
      inst_addr    <= inst_addr_d;
      fetch_req    <= fetch_req_d;
      fetch_addr   <= fetch_addr_d;
    end
  end

`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cycles <= 32'h0;
    end else if (rdy_in && start_decode && !issue_signal && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed stimulus pushes expected fetch
// requests and decoder presentations; a negedge monitor pops and compares them.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, wrong_predicted, issue_signal, jalr_stall, fetch_valid;
  logic [31:0] correct_pc, next_pc, fetch_inst;
  logic        start_decode, fetch_req;
  logic [31:0] inst, inst_addr, fetch_addr;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_snap;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_dec[$];

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .wrong_predicted(wrong_predicted),
    .correct_pc     (correct_pc),
    .issue_signal   (issue_signal),
    .jalr_stall     (jalr_stall),
    .next_pc        (next_pc),
    .start_decode   (start_decode),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_valid    (fetch_valid),
`ifdef IF_STALL_CNT_EN
    .fetch_inst     (fetch_inst),
    .stall_cycles   (stall_cycles)
`else
    .fetch_inst     (fetch_inst)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a * 32'd3 + 32'h13);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: pulse fetch_valid lat cycles after the current request appeared.
  task automatic fetch_resp(input int lat);
    for (int i = 0; i < lat - 1; i++) tick();
    fetch_valid = 1'b1;
    fetch_inst  = mem_word(fetch_addr);
    tick();
    fetch_valid = 1'b0;
    fetch_inst  = 32'hDEAD_BEEF;
  endtask

  // Monitor: a new request is a rising fetch_req or an address change while held.
  logic        prev_req = 1'b0;
  logic        prev_sd  = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    if (!rst_in) begin
      if (fetch_req && (!prev_req || fetch_addr != prev_addr)) begin
        if (exp_req.size() == 0) check("unexpected_req", {32'h0, fetch_addr}, 64'hFFFF_FFFF);
        else check("fetch_addr", {32'h0, fetch_addr}, {32'h0, exp_req.pop_front()});
      end
      if (start_decode && !prev_sd) begin
        if (exp_dec.size() == 0) check("unexpected_decode", {inst, inst_addr}, 64'h0);
        else check("decode_inst_addr", {inst, inst_addr}, exp_dec.pop_front());
      end
    end
    prev_req  = (fetch_req === 1'b1);
    prev_sd   = (start_decode === 1'b1);
    prev_addr = fetch_addr;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_start_decode"}, {63'h0, start_decode}, 64'h0);
    check({tag, "_inst"},         {32'h0, inst},         64'h0);
    check({tag, "_inst_addr"},    {32'h0, inst_addr},    64'h0);
    check({tag, "_fetch_req"},    {63'h0, fetch_req},    64'h0);
    check({tag, "_fetch_addr"},   {32'h0, fetch_addr},   64'h0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; wrong_predicted = 1'b0; issue_signal = 1'b0;
    jalr_stall = 1'b0; fetch_valid = 1'b0; correct_pc = 32'h0; next_pc = 32'h0;
    fetch_inst = 32'hDEAD_BEEF;
    tick(); tick();
    check_zero_outputs("reset");
`ifdef IF_STALL_CNT_EN
    check("reset_stall_cycles", {32'h0, stall_cycles}, 64'h0);
`endif

    // First fetch at RESET_PC, memory answers after 3 cycles.
    exp_req.push_back(32'h0);
    exp_dec.push_back({32'h0050_0093, 32'h0});
    rst_in = 1'b0;
    tick();
    fetch_resp(3);

    // Issue with next_pc=4.
    exp_req.push_back(32'h4);
    issue_signal = 1'b1; next_pc = 32'h4;
    tick();
    issue_signal = 1'b0;
    check("issue_start_decode_low", {63'h0, start_decode}, 64'h0);
    exp_dec.push_back({mem_word(32'h4), 32'h4});
    fetch_resp(1);

    // jalr stall: instruction held, no refetch.
    jalr_stall = 1'b1;
`ifdef IF_STALL_CNT_EN
    stall_snap = stall_cycles;
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_start_decode", {63'h0, start_decode}, 64'h1);
      check("stall_fetch_req", {63'h0, fetch_req}, 64'h0);
      check("stall_inst", {inst, inst_addr}, {mem_word(32'h4), 32'h4});
    end
`ifdef IF_STALL_CNT_EN
    check("stall_cycles_delta", {32'h0, stall_cycles - stall_snap}, 64'd5);
`endif
    jalr_stall = 1'b0;
    exp_req.push_back(32'h100);
    issue_signal = 1'b1; next_pc = 32'h100;
    tick();
    issue_signal = 1'b0;
    exp_dec.push_back({mem_word(32'h100), 32'h100});
    fetch_resp(2);

    // Request at 8, flush to 0x40 with the response arriving two cycles later.
    exp_req.push_back(32'h8);
    issue_signal = 1'b1; next_pc = 32'h8;
    tick();
    issue_signal = 1'b0;
    wrong_predicted = 1'b1; correct_pc = 32'h40;
    tick();
    wrong_predicted = 1'b0;
    check("drain_fetch_req", {63'h0, fetch_req}, 64'h0);
    check("drain_start_decode", {63'h0, start_decode}, 64'h0);
    exp_req.push_back(32'h40);
    tick();
    fetch_valid = 1'b1; fetch_inst = 32'h1111_1111;
    tick();
    fetch_valid = 1'b0;
    check("post_drain_start_decode", {63'h0, start_decode}, 64'h0);

    // Flush and response in the same cycle.
    exp_req.push_back(32'h80);
    wrong_predicted = 1'b1; correct_pc = 32'h80;
    fetch_valid = 1'b1; fetch_inst = 32'h2222_2222;
    tick();
    wrong_predicted = 1'b0; fetch_valid = 1'b0;
    check("same_cycle_start_decode", {63'h0, start_decode}, 64'h0);
    exp_dec.push_back({mem_word(32'h80), 32'h80});
    fetch_resp(2);

    // rdy pause in HOLD with a pending issue.
    rdy_in = 1'b0; issue_signal = 1'b1; next_pc = 32'hC;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pause_start_decode", {63'h0, start_decode}, 64'h1);
      check("pause_fetch_req", {63'h0, fetch_req}, 64'h0);
      check("pause_inst", {inst, inst_addr}, {mem_word(32'h80), 32'h80});
    end
    exp_req.push_back(32'hC);
    rdy_in = 1'b1;
    tick();
    issue_signal = 1'b0;
    tick();

    // Reset in the middle of a request.
    rst_in = 1'b1;
    tick();
    check_zero_outputs("midreq_reset");
`ifdef IF_STALL_CNT_EN
    check("midreq_stall_cycles", {32'h0, stall_cycles}, 64'h0);
`endif
    exp_req.push_back(32'h0);
    rst_in = 1'b0;
    tick();
    tick();
    check("req_queue_drained", 64'(exp_req.size()), 64'h0);
    check("dec_queue_drained", 64'(exp_dec.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
